inst_fetch_ctrl: RTL and testbench
==================================

Name: inst_fetch_ctrl

Overview:
- Fetch-stage sequencer for the processor's 256-byte instruction memory.
- Holds the program counter and drives the memory's byte address. The memory is combinational, read-only, and returns a 16-bit little-endian word.
- Each fetched word is pushed, tagged with its PC, into a small instruction queue. The queue feeds decode through a valid/ready handshake.
- Handles branch/jump redirects (flush plus PC reload), decode back-pressure and a fetch enable.

Parameters:
- RESET_PC, 8'h00, PC value loaded on reset; bit 0 is forced to 0.
- DEPTH, 2, instruction queue entries; legal values are 2 or 4.
- PC_STEP, 2, bytes per instruction.

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst  input  1  synchronous, active-low reset; sampled on the rising edge of clk.
- fetch_en  input  1  fetch permitted when 1; when 0, the PC and pushes freeze and pops continue.
- redirect  input  1  branch/jump taken; highest priority.
- redirect_pc  input  8  new PC; bit 0 is ignored.
- mem_addr  output  8  address to the instruction memory; always equals the current PC.
- mem_q  input  16  instruction word returned by the memory in the same cycle.
- id_valid  output  1  queue head holds a valid instruction.
- id_ready  input  1  decode accepts the head this cycle.
- id_inst  output  16  head instruction word.
- id_pc  output  8  PC of the head instruction.
- q_count  output  clog2(DEPTH)+1  current number of queue entries (debug).

Behaviour:
- Reset (rst=0 at a clock edge):
  - pc <= RESET_PC & 8'hFE; queue emptied (head = tail = 0, count = 0).
  - Outputs after reset: id_valid=0, id_inst=16'h0000, id_pc=8'h00, q_count=0, mem_addr=RESET_PC.
  - Reset overrides redirect and handshakes; reset arriving mid-stream discards all queued entries.
- mem_addr = pc, combinational from the register. mem_q is sampled in the same cycle, so there is zero wait-state.
- pop = id_valid & id_ready.
- push = fetch_en & ~redirect & (count < DEPTH | pop).
  - A full queue with a simultaneous pop still pushes, which sustains 1 instruction per cycle.
- On push:
  - entry[tail] <= {pc, mem_q}; tail advances modulo DEPTH; pc <= pc + PC_STEP.
  - PC arithmetic is 8-bit: 8'hFE + 2 wraps to 8'h00 with no flag.
- On redirect (rst=1):
  - pc <= {redirect_pc[7:1], 1'b0}.
  - Queue is flushed (count=0); any same-cycle pop is ignored, i.e. no double-consume is reported.
  - No push that cycle.
  - The first post-redirect instruction is visible on id_valid two edges after redirect is asserted: fetch at the next edge, then valid.
- If neither push nor pop: state holds. If pop only: head advances, count decrements.
- Latency:
  - One-cycle fetch-to-valid: a word fetched at edge N appears on id_valid/id_inst after edge N.
  - Output ordering is strict PC order between redirects.
- Outputs id_inst and id_pc come from the head entry via registered storage (no combinational path from mem_q).
  - When empty, they hold the last head value; consumers must qualify them with id_valid.
- Sustained throughput is 1 instruction/cycle with id_ready=1 and fetch_en=1.
- Stall (id_ready=0): the queue fills to DEPTH, then push stops and pc holds. mem_addr stays at the next unfetched PC.
- fetch_en=0 with a redirect: the redirect is still applied (pc reload plus flush).
- Illegal state (count > DEPTH) is unreachable; assertions in the bench check for it.

Decomposition:
- Shared package cpu_pkg:
  - PC_W=8, INST_W=16, RESET_PC default.
  - Fetch entry typedef {pc[7:0], inst[15:0]}.
- One natural sub-module: fetch_queue, a parameterised DEPTH-entry synchronous FIFO.
  - It provides push/pop/flush, count, and head data.
  - Flush has priority over push and pop.
- The PC register and push/redirect logic stay in inst_fetch_ctrl.

Test Plan:
- Reset then stream: hold rst=0 for 2 cycles, release, id_ready=1, fetch_en=1, memory loaded with words 0x0000@0x00, 0x0000@0x02, 0x0070@0x04, 0xFFE0@0x06 → id_pc sequence 00, 02, 04, 06 with id_inst 0000, 0000, 0070, FFE0 on consecutive cycles; first id_valid=1 one cycle after reset release.
- Back-pressure: id_ready=0 for 5 cycles from PC=0x00 → q_count rises to 2 and stays; mem_addr holds at 0x04; on id_ready=1 the outputs are 00, 02, 04 in order with no gaps or duplicates.
- Full plus simultaneous pop/push: with count=2 and id_ready=1 steady → count stays 2 and one instruction retires per cycle.
- Redirect mid-stall: queue full (PCs 0x10, 0x12), assert redirect with redirect_pc=0x3D and id_ready=1 → nothing is popped; next cycle count=0, mem_addr=0x3C; following cycle id_pc=0x3C, id_inst = word at 0x3C (0x1FE0).
- Wrap-around: redirect to 0xFC, stream → id_pc sequence FC, FE, 00, 02.
- Reset mid-operation: rst=0 while count=2 and redirect=1 → next cycle id_valid=0, q_count=0, mem_addr=RESET_PC; the redirect is discarded.

Source files
------------

// File: rtl/cpu_pkg.sv
// Shared CPU front-end definitions: datapath widths, reset PC and the fetch queue entry.
package cpu_pkg;

    localparam int PC_W   = 8;
    localparam int INST_W = 16;

    localparam logic [PC_W-1:0] RESET_PC_DEFAULT = 8'h00;
    localparam int              PC_STEP_DEFAULT  = 2;

    typedef logic [PC_W-1:0]   pc_t;
    typedef logic [INST_W-1:0] inst_t;

    typedef struct packed {
        pc_t   pc;
        inst_t inst;
    } fetch_entry_t;

    // Instructions are halfword aligned, so bit 0 of any PC source is dropped.
    function automatic pc_t align_pc(input pc_t raw_pc);
        return {raw_pc[PC_W-1:1], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_queue.sv
// DEPTH-entry synchronous FIFO of fetched instructions; flush beats push and pop,
// and the head entry is presented from a register so it holds while the queue is empty.
module fetch_queue
    import cpu_pkg::*;
#(
    parameter  int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               flush,
    input  logic               push,
    input  logic               pop,
    input  fetch_entry_t       wdata,
    output logic [CNT_W-1:0]   count,
    output logic               valid,
    output fetch_entry_t       head
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    fetch_entry_t            mem_q [DEPTH];
    logic [PTR_W-1:0]        head_ptr_q, head_ptr_d;
    logic [PTR_W-1:0]        tail_ptr_q, tail_ptr_d;
    logic [CNT_W-1:0]        count_q, count_d;
    fetch_entry_t            head_q, head_d;

    logic                    pop_ok;
    logic                    push_ok;
    logic [CNT_W-1:0]        remaining;

    assign pop_ok    = pop & (count_q != '0);
    assign push_ok   = push & ((count_q < DEPTH_C) | pop_ok);
    assign remaining = count_q - CNT_W'(pop_ok);

    always_comb begin
        head_ptr_d = head_ptr_q;
        tail_ptr_d = tail_ptr_q;
        count_d    = count_q;
        head_d     = head_q;
        if (flush) begin
            head_ptr_d = '0;
            tail_ptr_d = '0;
            count_d    = '0;
        end else begin
            if (push_ok) tail_ptr_d = tail_ptr_q + PTR_W'(1);
            if (pop_ok)  head_ptr_d = head_ptr_q + PTR_W'(1);
            count_d = remaining + CNT_W'(push_ok);
            // An entry written into an otherwise empty queue becomes the head directly.
            if (remaining == '0) begin
                if (push_ok) head_d = wdata;
            end else begin
                head_d = mem_q[head_ptr_d];
            end
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples the pre-edge values regardless of statement order.
        if (!rst) begin
            head_ptr_q <= '0;
            tail_ptr_q <= '0;
            count_q    <= '0;
            head_q     <= '0;
        end else begin
            head_ptr_q <= head_ptr_d;
            tail_ptr_q <= tail_ptr_d;
            count_q    <= count_d;
            head_q     <= head_d;
        end
    end

    // NOTE: the storage array is deliberately left unreset; count gates every read,
    // and the visible head comes from head_q, which is reset.
    always_ff @(posedge clk) begin
        if (rst && !flush && push_ok) begin
            mem_q[tail_ptr_q] <= wdata;
        end
    end

    assign count = count_q;
    assign valid = (count_q != '0);
    assign head  = head_q;

endmodule

// File: rtl/inst_fetch_ctrl.sv
// Fetch-stage sequencer: owns the PC, reads the zero-wait-state instruction memory
// and pushes PC-tagged words into the decode queue; redirects flush and reload the PC.
module inst_fetch_ctrl
    import cpu_pkg::*;
#(
    parameter  logic [7:0] RESET_PC = RESET_PC_DEFAULT,
    parameter  int         DEPTH    = 2,
    parameter  int         PC_STEP  = PC_STEP_DEFAULT,
    localparam int         CNT_W    = $clog2(DEPTH) + 1
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               fetch_en,
    input  logic               redirect,
    input  logic [7:0]         redirect_pc,
    output logic [7:0]         mem_addr,
    input  logic [15:0]        mem_q,
    output logic               id_valid,
    input  logic               id_ready,
    output logic [15:0]        id_inst,
    output logic [7:0]         id_pc,
    output logic [CNT_W-1:0]   q_count
);

    localparam pc_t              STEP    = PC_W'(PC_STEP);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    pc_t          pc_q, pc_d;
    logic         pop;
    logic         push;
    fetch_entry_t wr_entry;
    fetch_entry_t head_entry;
    logic         q_valid;
    logic [CNT_W-1:0] count;

    assign pop  = q_valid & id_ready;
    assign push = fetch_en & ~redirect & ((count < DEPTH_C) | pop);

    assign wr_entry = '{pc: pc_q, inst: mem_q};

    // Redirect outranks fetching; PC wraps naturally in 8 bits.
    always_comb begin
        pc_d = pc_q;
        if (redirect) begin
            pc_d = align_pc(redirect_pc);
        end else if (push) begin
            pc_d = pc_q + STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            pc_q <= align_pc(RESET_PC);
        end else begin
            pc_q <= pc_d;
        end
    end

    fetch_queue #(
        .DEPTH (DEPTH)
    ) u_queue (
        .clk   (clk),
        .rst   (rst),
        .flush (redirect),
        .push  (push),
        .pop   (pop),
        .wdata (wr_entry),
        .count (count),
        .valid (q_valid),
        .head  (head_entry)
    );

    assign mem_addr = pc_q;
    assign id_valid = q_valid;
    assign id_inst  = head_entry.inst;
    assign id_pc    = head_entry.pc;
    assign q_count  = count;

endmodule

// File: tb/tb_inst_fetch_ctrl.sv
// Directed bench for inst_fetch_ctrl: streaming, back-pressure, redirect, PC wrap and reset.
module tb_inst_fetch_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        fetch_en;
    logic        redirect;
    logic [7:0]  redirect_pc;
    logic [7:0]  mem_addr;
    logic [15:0] mem_q;
    logic        id_valid;
    logic        id_ready;
    logic [15:0] id_inst;
    logic [7:0]  id_pc;
    logic [1:0]  q_count;

    logic [7:0]  mem_b [256];
    int          checks   = 0;
    int          failures = 0;

    always #5 clk = ~clk;

    assign mem_q = {mem_b[mem_addr + 8'd1], mem_b[mem_addr]};

    inst_fetch_ctrl dut (
        .clk         (clk),
        .rst         (rst),
        .fetch_en    (fetch_en),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .mem_addr    (mem_addr),
        .mem_q       (mem_q),
        .id_valid    (id_valid),
        .id_ready    (id_ready),
        .id_inst     (id_inst),
        .id_pc       (id_pc),
        .q_count     (q_count)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One rising edge, then return at the following falling edge for sampling/driving.
    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    always @(negedge clk) begin
        if (rst === 1'b1) begin
            assert (q_count <= 2'd2) else begin
                failures++;
                $error("FAIL q_count_bound observed=%0d expected<=2", q_count);
            end
        end
    end

    initial begin
        // Default byte image: i ^ 8'hC3, with a few hand-loaded words on top.
        for (int i = 0; i < 256; i++) mem_b[i] = 8'(i) ^ 8'hC3;
        {mem_b[8'h01], mem_b[8'h00]} = 16'h0000;
        {mem_b[8'h03], mem_b[8'h02]} = 16'h0000;
        {mem_b[8'h05], mem_b[8'h04]} = 16'h0070;
        {mem_b[8'h07], mem_b[8'h06]} = 16'hFFE0;
        {mem_b[8'h3D], mem_b[8'h3C]} = 16'h1FE0;

        rst = 1'b0; fetch_en = 1'b1; id_ready = 1'b1; redirect = 1'b0; redirect_pc = 8'h00;
        @(negedge clk);
        step(); step();
        check("rst_valid", 32'(id_valid), 32'h0);
        check("rst_inst",  32'(id_inst),  32'h0000);
        check("rst_pc",    32'(id_pc),    32'h00);
        check("rst_count", 32'(q_count),  32'h0);
        check("rst_addr",  32'(mem_addr), 32'h00);

        // Streaming at one instruction per cycle.
        rst = 1'b1;
        step();
        check("s0_valid", 32'(id_valid), 32'h1);
        check("s0_pc",    32'(id_pc),    32'h00);
        check("s0_inst",  32'(id_inst),  32'h0000);
        step();
        check("s1_pc",    32'(id_pc),    32'h02);
        check("s1_inst",  32'(id_inst),  32'h0000);
        step();
        check("s2_pc",    32'(id_pc),    32'h04);
        check("s2_inst",  32'(id_inst),  32'h0070);
        step();
        check("s3_pc",    32'(id_pc),    32'h06);
        check("s3_inst",  32'(id_inst),  32'hFFE0);
        check("s3_valid", 32'(id_valid), 32'h1);

        // Back-pressure from PC 0x00.
        rst = 1'b0;
        step();
        rst = 1'b1; id_ready = 1'b0;
        step();
        check("bp1_count", 32'(q_count), 32'h1);
        step(); step(); step(); step();
        check("bp5_count", 32'(q_count),  32'h2);
        check("bp5_addr",  32'(mem_addr), 32'h04);
        check("bp5_pc",    32'(id_pc),    32'h00);
        id_ready = 1'b1;
        step();
        check("bp_r1_pc",    32'(id_pc),   32'h02);
        check("bp_r1_count", 32'(q_count), 32'h2);
        step();
        check("bp_r2_pc",    32'(id_pc),   32'h04);
        check("bp_r2_inst",  32'(id_inst), 32'h0070);
        check("bp_r2_count", 32'(q_count), 32'h2);
        step();
        check("full_pc",    32'(id_pc),   32'h06);
        check("full_count", 32'(q_count), 32'h2);

        // Fill with 0x10/0x12, then redirect while full.
        id_ready = 1'b0; redirect = 1'b1; redirect_pc = 8'h10;
        step();
        redirect = 1'b0;
        check("fill_count0", 32'(q_count), 32'h0);
        step(); step();
        check("fill_count", 32'(q_count),  32'h2);
        check("fill_addr",  32'(mem_addr), 32'h14);
        check("fill_pc",    32'(id_pc),    32'h10);
        check("fill_inst",  32'(id_inst),  32'hD2D3);
        redirect = 1'b1; redirect_pc = 8'h3D; id_ready = 1'b1;
        step();
        redirect = 1'b0;
        check("rd_count", 32'(q_count),  32'h0);
        check("rd_valid", 32'(id_valid), 32'h0);
        check("rd_addr",  32'(mem_addr), 32'h3C);
        check("rd_hold",  32'(id_pc),    32'h10);
        step();
        check("rd_pc",    32'(id_pc),    32'h3C);
        check("rd_inst",  32'(id_inst),  32'h1FE0);
        check("rd_valid2", 32'(id_valid), 32'h1);

        // PC wrap across 0xFE -> 0x00.
        redirect = 1'b1; redirect_pc = 8'hFC;
        step();
        redirect = 1'b0;
        check("wr_addr", 32'(mem_addr), 32'hFC);
        step();
        check("wr0_pc",   32'(id_pc),   32'hFC);
        check("wr0_inst", 32'(id_inst), 32'h3E3F);
        step();
        check("wr1_pc",   32'(id_pc),   32'hFE);
        check("wr1_inst", 32'(id_inst), 32'h3C3D);
        step();
        check("wr2_pc",   32'(id_pc),   32'h00);
        step();
        check("wr3_pc",   32'(id_pc),   32'h02);

        // fetch_en=0: pops continue, PC and pushes freeze.
        fetch_en = 1'b0;
        step();
        check("fe_valid", 32'(id_valid), 32'h0);
        check("fe_addr",  32'(mem_addr), 32'h04);
        step();
        check("fe_addr2", 32'(mem_addr), 32'h04);
        check("fe_count", 32'(q_count),  32'h0);

        // fetch_en=0 with a redirect still reloads the PC.
        redirect = 1'b1; redirect_pc = 8'h41;
        step();
        redirect = 1'b0;
        check("fe_rd_addr", 32'(mem_addr), 32'h40);

        // Reset while full with a simultaneous redirect.
        fetch_en = 1'b1; id_ready = 1'b0;
        step(); step();
        check("mr_count_pre", 32'(q_count), 32'h2);
        rst = 1'b0; redirect = 1'b1; redirect_pc = 8'h80;
        step();
        check("mr_valid", 32'(id_valid), 32'h0);
        check("mr_count", 32'(q_count),  32'h0);
        check("mr_addr",  32'(mem_addr), 32'h00);
        check("mr_inst",  32'(id_inst),  32'h0000);
        rst = 1'b1; redirect = 1'b0;
        step();
        check("mr_post_pc",    32'(id_pc),    32'h00);
        check("mr_post_valid", 32'(id_valid), 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
